// File: rtl/dest_reg_track.sv
// dest_reg_track: carries the EX destination register and its write enable
// through the MEM and WB pipeline registers, and derives the ALU operand
// forwarding selects and the load-use stall from that state.
// Optional feature macro: HAZARD_CNT_EN adds a saturating stall counter
// output (stall_cnt_o).
module dest_reg_track #(
  parameter int AW        = 5,
  parameter bit ZERO_KILL = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_i,
  input  logic          flush_i,
  input  logic          ex_valid_i,
  input  logic [AW-1:0] ex_dest_i,
  input  logic          ex_reg_write_i,
  input  logic          ex_mem_read_i,
  input  logic [AW-1:0] ex_rs_i,
  input  logic [AW-1:0] ex_rt_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  output logic [AW-1:0] mem_dest_o,
  output logic          mem_reg_write_o,
  output logic [AW-1:0] wb_dest_o,
  output logic          wb_reg_write_o,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o,
  output logic          load_use_stall_o
`ifdef HAZARD_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  // A write only counts when enabled and, with ZERO_KILL, not aimed at r0.
  function automatic logic eff_write(input logic we, input logic [AW-1:0] dest);
    return we & (~ZERO_KILL | (dest != {AW{1'b0}}));
  endfunction

  // Operand select: MEM wins over WB when both hold the same destination.
  function automatic logic [1:0] fwd_sel(input logic          mem_eff,
                                         input logic [AW-1:0] mem_dest,
                                         input logic          wb_eff,
                                         input logic [AW-1:0] wb_dest,
                                         input logic [AW-1:0] src);
    if (mem_eff && (mem_dest == src)) begin
      return 2'b10;
    end else if (wb_eff && (wb_dest == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  logic [AW-1:0] mem_dest_r;
  logic          mem_we_r;
  logic [AW-1:0] wb_dest_r;
  logic          wb_we_r;
  logic          mem_eff_s;
  logic          wb_eff_s;
  logic [1:0]    fwd_a_s;
  logic [1:0]    fwd_b_s;
  logic          dest_hit_s;
  logic          stall_s;

  // MEM stage: advance from EX, or hold; a flush under hold still kills the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dest_r <= {AW{1'b0}};
      mem_we_r   <= 1'b0;
    end else if (!hold_i) begin
      mem_dest_r <= ex_dest_i;
      mem_we_r   <= ex_reg_write_i & ex_valid_i & ~flush_i;
    end else if (flush_i) begin
      mem_dest_r <= mem_dest_r;
      mem_we_r   <= 1'b0;
    end else begin
      mem_dest_r <= mem_dest_r;
      mem_we_r   <= mem_we_r;
    end
  end

  // WB stage: copy MEM on every unheld edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_dest_r <= {AW{1'b0}};
      wb_we_r   <= 1'b0;
    end else if (!hold_i) begin
      wb_dest_r <= mem_dest_r;
      wb_we_r   <= mem_we_r;
    end else begin
      wb_dest_r <= wb_dest_r;
      wb_we_r   <= wb_we_r;
    end
  end

  // Forwarding selects and load-use stall from the carried state and EX/ID inputs.
  always_comb begin
    mem_eff_s  = eff_write(mem_we_r, mem_dest_r);
    wb_eff_s   = eff_write(wb_we_r, wb_dest_r);
    fwd_a_s    = fwd_sel(mem_eff_s, mem_dest_r, wb_eff_s, wb_dest_r, ex_rs_i);
    fwd_b_s    = fwd_sel(mem_eff_s, mem_dest_r, wb_eff_s, wb_dest_r, ex_rt_i);
    dest_hit_s = (ex_dest_i == id_rs_i) | (ex_dest_i == id_rt_i);
    stall_s    = ex_valid_i & ex_mem_read_i & ~flush_i &
                 eff_write(ex_reg_write_i, ex_dest_i) & dest_hit_s;
  end

  assign mem_dest_o       = mem_dest_r;
  assign mem_reg_write_o  = mem_we_r;
  assign wb_dest_o        = wb_dest_r;
  assign wb_reg_write_o   = wb_we_r;
  assign fwd_a_o          = fwd_a_s;
  assign fwd_b_o          = fwd_b_s;
  assign load_use_stall_o = stall_s;

`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Count stalled edges regardless of hold, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_dest_reg_track.sv
// Directed self-checking bench for dest_reg_track (default parameters).
module tb_dest_reg_track;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold_i, flush_i, ex_valid_i, ex_reg_write_i, ex_mem_read_i;
  logic [4:0] ex_dest_i, ex_rs_i, ex_rt_i, id_rs_i, id_rt_i;
  logic [4:0] mem_dest_o, wb_dest_o;
  logic       mem_reg_write_o, wb_reg_write_o, load_use_stall_o;
  logic [1:0] fwd_a_o, fwd_b_o;
`ifdef HAZARD_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dest_reg_track dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_dest_i(ex_dest_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .mem_dest_o(mem_dest_o), .mem_reg_write_o(mem_reg_write_o),
    .wb_dest_o(wb_dest_o), .wb_reg_write_o(wb_reg_write_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .load_use_stall_o(load_use_stall_o)
`ifdef HAZARD_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0;
    ex_reg_write_i = 1'b0; ex_mem_read_i = 1'b0; ex_dest_i = 5'd0;
    ex_rs_i = 5'd0; ex_rt_i = 5'd0; id_rs_i = 5'd0; id_rt_i = 5'd0;
    #12 rst_n = 1'b1;

    // reset state
    check_val("rst_mem_dest", mem_dest_o, 32'd0);
    check_val("rst_mem_we", mem_reg_write_o, 32'd0);
    check_val("rst_wb_dest", wb_dest_o, 32'd0);
    check_val("rst_wb_we", wb_reg_write_o, 32'd0);
    check_val("rst_fwd_a", fwd_a_o, 32'd0);

    // pipe latency
    ex_valid_i = 1'b1; ex_reg_write_i = 1'b1; ex_dest_i = 5'd5;
    step();
    check_val("pipe_mem_dest", mem_dest_o, 32'd5);
    check_val("pipe_mem_we", mem_reg_write_o, 32'd1);
    check_val("pipe_wb_we_early", wb_reg_write_o, 32'd0);
    ex_valid_i = 1'b0;
    step();
    check_val("pipe_wb_dest", wb_dest_o, 32'd5);
    check_val("pipe_wb_we", wb_reg_write_o, 32'd1);
    check_val("pipe_mem_we_killed", mem_reg_write_o, 32'd0);

    // forward priority
    ex_valid_i = 1'b1; ex_dest_i = 5'd7;
    step();
    step();
    ex_rs_i = 5'd7; ex_rt_i = 5'd7;
    #1;
    check_val("fwd_a_mem_prio", fwd_a_o, 32'd2);
    check_val("fwd_b_mem_prio", fwd_b_o, 32'd2);
    ex_valid_i = 1'b0;
    step();
    check_val("fwd_a_wb", fwd_a_o, 32'd1);
    check_val("fwd_b_wb", fwd_b_o, 32'd1);
    ex_rs_i = 5'd8;
    #1;
    check_val("fwd_a_nomatch", fwd_a_o, 32'd0);

    // zero register
    ex_valid_i = 1'b1; ex_dest_i = 5'd0;
    step();
    ex_rs_i = 5'd0; ex_rt_i = 5'd0;
    #1;
    check_val("zero_mem_we", mem_reg_write_o, 32'd1);
    check_val("zero_fwd_a", fwd_a_o, 32'd0);
    check_val("zero_fwd_b", fwd_b_o, 32'd0);
    ex_mem_read_i = 1'b1; id_rs_i = 5'd0; id_rt_i = 5'd0;
    #1;
    check_val("zero_stall", load_use_stall_o, 32'd0);

    // load-use
    ex_dest_i = 5'd9; id_rt_i = 5'd9;
    #1;
    check_val("lu_stall", load_use_stall_o, 32'd1);
    flush_i = 1'b1;
    #1;
    check_val("lu_stall_flush", load_use_stall_o, 32'd0);
    step();
    check_val("lu_flush_mem_we", mem_reg_write_o, 32'd0);
    check_val("lu_flush_mem_dest", mem_dest_o, 32'd9);

    // hold + flush
    flush_i = 1'b0; ex_mem_read_i = 1'b0; ex_dest_i = 5'd6;
    step();
    ex_dest_i = 5'd3;
    step();
    check_val("hf_pre_mem", {mem_dest_o, mem_reg_write_o}, {26'd0, 5'd3, 1'b1});
    check_val("hf_pre_wb", {wb_dest_o, wb_reg_write_o}, {26'd0, 5'd6, 1'b1});
    hold_i = 1'b1; flush_i = 1'b1; ex_dest_i = 5'd4;
    step();
    check_val("hf_mem_we", mem_reg_write_o, 32'd0);
    check_val("hf_mem_dest", mem_dest_o, 32'd3);
    check_val("hf_wb", {wb_dest_o, wb_reg_write_o}, {26'd0, 5'd6, 1'b1});
    flush_i = 1'b0; ex_mem_read_i = 1'b1; id_rs_i = 5'd4;
    #1;
    check_val("hold_stall", load_use_stall_o, 32'd1);
    ex_mem_read_i = 1'b0;
    step();
    check_val("hold_mem", {mem_dest_o, mem_reg_write_o}, {26'd0, 5'd3, 1'b0});
    check_val("hold_wb", {wb_dest_o, wb_reg_write_o}, {26'd0, 5'd6, 1'b1});

    // mid-stream reset
    hold_i = 1'b0; ex_dest_i = 5'd11; ex_rs_i = 5'd11;
    step();
    step();
    check_val("pre_rst_fwd_a", fwd_a_o, 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check_val("mrst_mem", {mem_dest_o, mem_reg_write_o}, 32'd0);
    check_val("mrst_wb", {wb_dest_o, wb_reg_write_o}, 32'd0);
    check_val("mrst_fwd_a", fwd_a_o, 32'd0);
    ex_mem_read_i = 1'b1; id_rt_i = 5'd11;
    #1;
    check_val("mrst_stall", load_use_stall_o, 32'd1);
    rst_n = 1'b1;

    // stall counter (three stalled edges, then one idle edge)
    step();
    step();
    step();
    ex_mem_read_i = 1'b0;
`ifdef HAZARD_CNT_EN
    check_val("cnt_3", stall_cnt_o, 32'd3);
`endif
    step();
    check_val("idle_stall", load_use_stall_o, 32'd0);
`ifdef HAZARD_CNT_EN
    check_val("cnt_hold_3", stall_cnt_o, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
